// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: reset vector, bubble encoding, FSM states and the IF/ID record.
package fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic {HOLD, RUN} fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  function automatic if_id_t bubble(input logic [31:0] nop);
    bubble = '{instr: nop, pc: 32'h0, pcplus4: 32'h0, valid: 1'b0};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its neighbours (hazard unit, execute redirect, imem, decode).
interface fetch_if #(parameter int CNT_W = 32);

  logic             stallF;
  logic             stallD;
  logic             flushD;
  logic             pcsrcE;
  logic [31:0]      pctargetE;
  logic [31:0]      pcF;
  logic [31:0]      instrF;
  logic [31:0]      instrD;
  logic [31:0]      pcD;
  logic [31:0]      pcplus4D;
  logic             validD;
  logic             misalignE;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    input  stallF, stallD, flushD, pcsrcE, pctargetE, instrF,
    output pcF, instrD, pcD, pcplus4D, validD, misalignE, fetch_cnt
  );

  modport slave (
    output stallF, stallD, flushD, pcsrcE, pctargetE, instrF,
    input  pcF, instrD, pcD, pcplus4D, validD, misalignE, fetch_cnt
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// PC register with redirect > stall > +4 next-PC selection; misalign is a registered one-cycle flag.
// Next PC takes effect one edge later; run=0 freezes the PC at its reset value.
module pc_reg #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic        misalign
);

  logic [31:0] pc_next;
  logic        misalign_next;

  always_comb begin
    pc_next       = pc;
    misalign_next = 1'b0;
    if (run) begin
      if (redirect) begin
        // Low bits are dropped; the misalign flag tells execute the target was bad.
        pc_next       = {target[31:2], 2'b00};
        misalign_next = |target[1:0];
      end else if (!stall) begin
        pc_next = pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VECTOR;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_next;
      misalign <= misalign_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, IF/ID register (flush > stall > load), HOLD/RUN start-up FSM and valid-fetch counter.
// instrF at pcF reaches instrD one cycle later; stallF/stallD hold PC and IF/ID, redirect overrides stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = fetch_pkg::NOP_INSTR,
  parameter int          CNT_W        = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);

  import fetch_pkg::*;

  fetch_state_e     state_q, state_d;
  logic             run;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             misalign;
  logic             kill;
  logic             load;
  if_id_t           if_id_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HOLD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      HOLD: state_d = RUN;
      RUN:  run     = 1'b1;
    endcase
  end

  pc_reg #(.RESET_VECTOR(RESET_VECTOR)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .stall    (bus.stallF),
    .redirect (bus.pcsrcE),
    .target   (bus.pctargetE),
    .pc       (pc),
    .misalign (misalign)
  );

  assign pc_plus4 = pc + 32'd4;
  assign kill     = !run || bus.flushD || bus.pcsrcE;
  assign load     = !kill && !bus.stallD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= bubble(NOP_INSTR);
      cnt_q   <= '0;
    end else begin
      if (kill)
        if_id_q <= bubble(NOP_INSTR);
      else if (load)
        if_id_q <= '{instr: bus.instrF, pc: pc, pcplus4: pc_plus4, valid: 1'b1};
      if (load)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pcF       = pc;
  assign bus.misalignE = misalign;
  assign bus.instrD    = if_id_q.instr;
  assign bus.pcD       = if_id_q.pc;
  assign bus.pcplus4D  = if_id_q.pcplus4;
  assign bus.validD    = if_id_q.valid;
  assign bus.fetch_cnt = cnt_q;

endmodule
